// File: rtl/ddr2_host_pkg.sv
// Shared types and helpers for the DDR2 host ingress path: command encoding,
// the command-queue entry layout and burst sizing.
package ddr2_host_pkg;

  localparam int HOST_ADDR_W      = 25;
  localparam int HOST_DATA_W      = 16;
  localparam int DEFAULT_CQ_DEPTH = 8;
  localparam int DEFAULT_DQ_DEPTH = 64;

  typedef enum logic [2:0] {
    NOP0 = 3'd0,
    SCR  = 3'd1,
    SCW  = 3'd2,
    BLR  = 3'd3,
    BLW  = 3'd4,
    ATR  = 3'd5,
    ATW  = 3'd6,
    NOP7 = 3'd7
  } cmd_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  typedef struct packed {
    cmd_e                   cmd;
    logic [1:0]             sz;
    logic [2:0]             op;
    logic [HOST_ADDR_W-1:0] addr;
  } cq_entry_t;

  // Burst length in words: 8*(sz+1), i.e. 8, 16, 24 or 32.
  function automatic logic [5:0] burst_len(input logic [1:0] sz);
    return {({1'b0, sz} + 3'd1), 3'b000};
  endfunction

endpackage

// File: rtl/ddr2_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and an underflow strobe.
// The head word reads as zero while empty so outputs are clean after reset.
module ddr2_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          pop_eff;
  logic          push_eff;

  // A pop on an empty queue is dropped; a push still lands even if it coincides.
  assign pop_eff   = pop && (count_q != '0);
  assign push_eff  = push && ((count_q != FULL_CNT) || pop_eff);
  assign underflow = pop && (count_q == '0);
  assign valid     = (count_q != '0);
  assign count     = count_q;
  assign rdata     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_host_ingress.sv
// Host-facing command/data acceptor: decodes host commands, runs the write
// burst FSM, and feeds the command and write-data queues drained by the scheduler.
//
// Handshake: a host command is taken on a rising edge where READY=1, the FSM
// is IDLE and NOTFULL (plus dspace for data-carrying commands) is high; the host
// holds CMD/DIN until then. Scheduler pops are taken on any edge with *_POP=1
// and *_VALID=1; a pop with VALID=0 is dropped and sets PROTO_ERR.
module ddr2_host_ingress
  import ddr2_host_pkg::*;
#(
  parameter int CQ_DEPTH = DEFAULT_CQ_DEPTH,
  parameter int DQ_DEPTH = DEFAULT_DQ_DEPTH,
  parameter int ADDR_W   = HOST_ADDR_W,  // must match the package entry layout
  parameter int DATA_W   = HOST_DATA_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      READY,
  input  logic [2:0]                CMD,
  input  logic [1:0]                SZ,
  input  logic [2:0]                OP,
  input  logic [ADDR_W-1:0]         ADDR,
  input  logic [DATA_W-1:0]         DIN,
  output logic                      NOTFULL,
  output logic [$clog2(DQ_DEPTH):0] FILLCOUNT,
  output logic                      CQ_VALID,
  output logic [2:0]                CQ_CMD,
  output logic [1:0]                CQ_SZ,
  output logic [2:0]                CQ_OP,
  output logic [ADDR_W-1:0]         CQ_ADDR,
  input  logic                      CQ_POP,
  output logic                      DQ_VALID,
  output logic [DATA_W-1:0]         DQ_DATA,
  input  logic                      DQ_POP,
  output logic                      PROTO_ERR,
  output logic                      DBG_STATE
);

  localparam int CQ_AW = $clog2(CQ_DEPTH);
  localparam int DQ_AW = $clog2(DQ_DEPTH);
  localparam int CQ_W  = $bits(cq_entry_t);
  localparam logic [CQ_AW:0] CQ_FULL = (CQ_AW+1)'(CQ_DEPTH);
  localparam logic [DQ_AW:0] DQ_FULL = (DQ_AW+1)'(DQ_DEPTH);

  burst_state_e    state_q;
  burst_state_e    state_d;
  logic [5:0]      remaining_q;
  logic            cq_push;
  logic            dq_push;
  logic            load_rem;
  logic            dspace;
  logic            notfull;
  logic [CQ_AW:0]  cq_count;
  logic [DQ_AW:0]  dq_count;
  logic            cq_under;
  logic            dq_under;
  cq_entry_t       cq_wentry;
  cq_entry_t       cq_rentry;
  logic [CQ_W-1:0] cq_rdata;
  cmd_e            cmd;

  assign cmd       = cmd_e'(CMD);
  assign notfull   = (cq_count < CQ_FULL);
  assign dspace    = (dq_count < DQ_FULL);
  assign NOTFULL   = notfull;
  assign FILLCOUNT = dq_count;
  assign DBG_STATE = state_q;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (READY && cmd == BLW && notfull && dspace) state_d = ST_BURST;
      ST_BURST: if (dspace && remaining_q == 6'd1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cq_push  = 1'b0;
    dq_push  = 1'b0;
    load_rem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (READY) begin
          case (cmd)
            SCR, BLR: cq_push = notfull;
            SCW, ATR, ATW: begin
              cq_push = notfull && dspace;
              dq_push = notfull && dspace;
            end
            BLW: begin
              cq_push  = notfull && dspace;
              dq_push  = notfull && dspace;
              load_rem = notfull && dspace;
            end
            default: ;
          endcase
        end
      end
      ST_BURST: dq_push = dspace;
      default: ;
    endcase
  end

  // Words still owed by the host after the one taken with the BLW command.
  always_ff @(posedge CLK) begin
    if (RESET)                               remaining_q <= '0;
    else if (load_rem)                       remaining_q <= burst_len(SZ) - 6'd1;
    else if (state_q == ST_BURST && dq_push) remaining_q <= remaining_q - 6'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET)                    PROTO_ERR <= 1'b0;
    else if (cq_under || dq_under) PROTO_ERR <= 1'b1;
  end

  assign cq_wentry = '{cmd: cmd, sz: SZ, op: OP, addr: ADDR};
  assign cq_rentry = cq_entry_t'(cq_rdata);
  assign CQ_CMD    = cq_rentry.cmd;
  assign CQ_SZ     = cq_rentry.sz;
  assign CQ_OP     = cq_rentry.op;
  assign CQ_ADDR   = cq_rentry.addr;

  ddr2_sync_fifo #(.W(CQ_W), .DEPTH(CQ_DEPTH)) u_cmd_q (
    .clk       (CLK),
    .rst       (RESET),
    .push      (cq_push),
    .wdata     (cq_wentry),
    .pop       (CQ_POP),
    .rdata     (cq_rdata),
    .valid     (CQ_VALID),
    .count     (cq_count),
    .underflow (cq_under)
  );

  ddr2_sync_fifo #(.W(DATA_W), .DEPTH(DQ_DEPTH)) u_data_q (
    .clk       (CLK),
    .rst       (RESET),
    .push      (dq_push),
    .wdata     (DIN),
    .pop       (DQ_POP),
    .rdata     (DQ_DATA),
    .valid     (DQ_VALID),
    .count     (dq_count),
    .underflow (dq_under)
  );

endmodule
